// File: rtl/analyzer_pkg.sv
// Shared definitions for the logic-analyzer trigger and capture path.
package analyzer_pkg;

    // Capture sequencer state encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Enabled-channel reduction mode
    localparam logic TRIG_MODE_AND = 1'b0;
    localparam logic TRIG_MODE_OR  = 1'b1;

    // Comparator operator codes used by the per-channel Basic_trigger stage
    typedef enum logic [2:0] {
        OP_EQ   = 3'd0,
        OP_NE   = 3'd1,
        OP_GT   = 3'd2,
        OP_LT   = 3'd3,
        OP_GE   = 3'd4,
        OP_LE   = 3'd5,
        OP_RISE = 3'd6,
        OP_FALL = 3'd7
    } trig_op_e;

endpackage

// File: rtl/trigger_combine.sv
// Reduces per-channel trigger terms to a single hit using the enable mask
// and AND/OR mode. Purely combinational so it can be chained for
// multi-stage triggers.
module trigger_combine
    import analyzer_pkg::*;
#(
    parameter int NUM_TRIG = 8
) (
    input  logic [NUM_TRIG-1:0] trig_in,
    input  logic [NUM_TRIG-1:0] trig_en,
    input  logic                trig_mode,
    output logic                hit
);

    // No enabled channels means free-run: every sample is a hit.
    always_comb begin
        if (trig_en == '0) begin
            hit = 1'b1;
        end else if (trig_mode == TRIG_MODE_OR) begin
            hit = |(trig_in & trig_en);
        end else begin
            hit = &(trig_in | ~trig_en);
        end
    end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Capture sequencer for the circular sample RAM: arm, pre-trigger fill,
// wait for trigger, post-trigger fill, done.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no capture, RAM write disabled, waiting for arm
//   PRE    | writing pre-trigger samples, trigger ignored
//   WAIT   | writing samples, each cycle may become the trigger sample
//   POST   | writing post-trigger samples
//   DONE   | capture complete, RAM holds DEPTH valid samples
module trigger_capture_ctrl
    import analyzer_pkg::*;
#(
    parameter int NUM_TRIG   = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_TRIG-1:0]   trig_in,
    input  logic [NUM_TRIG-1:0]   trig_en,
    input  logic                  trig_mode,
    input  logic [ADDR_WIDTH-1:0] pre_depth,
    input  logic                  arm,
    input  logic                  abort,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] post_len_q, post_len_d;
    logic                  triggered_q, triggered_d;

    logic                  hit;
    logic                  in_capture;
    logic [ADDR_WIDTH-1:0] pre_eff;
    logic [ADDR_WIDTH-1:0] post_len;

    trigger_combine #(
        .NUM_TRIG (NUM_TRIG)
    ) u_combine (
        .trig_in   (trig_in),
        .trig_en   (trig_en),
        .trig_mode (trig_mode),
        .hit       (hit)
    );

    // pre_depth is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and
    // the clamp reduces to a pass-through; the ring always keeps the
    // trigger sample plus pre_eff before and post_len after it.
    assign pre_eff  = pre_depth;
    assign post_len = ADDR_MAX - pre_eff;

    assign in_capture = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);

    // Next-state, counter and address logic; abort wins over hit and arm.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;
        post_len_d  = post_len_q;
        triggered_d = triggered_q;

        if (in_capture && abort) begin
            state_d     = S_IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        wr_addr_d   = '0;
                        cnt_d       = pre_eff;
                        post_len_d  = post_len;
                        triggered_d = 1'b0;
                        state_d     = (pre_eff != '0) ? S_PRE : S_WAIT;
                    end
                end
                S_PRE: begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    if (cnt_q == ADDR_ONE) begin
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q - ADDR_ONE;
                    end
                end
                S_WAIT: begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    if (hit) begin
                        trig_addr_d = wr_addr_q;
                        triggered_d = 1'b1;
                        cnt_d       = post_len_q;
                        state_d     = (post_len_q == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                    if (cnt_q == ADDR_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - ADDR_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Registered state with synchronous reset overriding any capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            post_len_q  <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            cnt_q       <= cnt_d;
            post_len_q  <= post_len_d;
            triggered_q <= triggered_d;
        end
    end

    assign wr_en     = in_capture;
    assign busy      = in_capture;
    assign wr_addr   = wr_addr_q;
    assign trig_addr = trig_addr_q;
    assign triggered = triggered_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: doc/trigger_capture_ctrl.md
Name: trigger_capture_ctrl

Overview:
- Sits directly downstream of the per-channel Basic_trigger comparators in the logic analyzer.
- Combines their `trig` outputs into one trigger condition using AND or OR mode with per-channel enables.
- Runs the capture sequence: arm, pre-trigger fill, wait for trigger, post-trigger fill, done.
- Drives the write side of the circular sample RAM and reports the address of the trigger sample to the readout logic.

Parameters:
- NUM_TRIG, 8: number of trigger inputs (one per Basic_trigger instance).
- ADDR_WIDTH, 10: sample RAM address width; DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  sample clock, same domain as the Basic_trigger instances.
- rst  in  1  synchronous, active-high reset.
- trig_in  in  NUM_TRIG  per-channel trigger terms (combinational `trig` outputs).
- trig_en  in  NUM_TRIG  per-channel enable; a disabled channel is a don't-care.
- trig_mode  in  1  0 = AND of enabled channels, 1 = OR of enabled channels.
- pre_depth  in  ADDR_WIDTH  pre-trigger sample count; latched at arm.
- arm  in  1  single-cycle start request.
- abort  in  1  cancel the capture in progress.
- wr_en  out  1  sample RAM write enable.
- wr_addr  out  ADDR_WIDTH  sample RAM write address.
- trig_addr  out  ADDR_WIDTH  RAM address of the trigger sample.
- busy  out  1  high in PRE, WAIT and POST.
- triggered  out  1  trigger has been accepted in the current capture.
- done  out  1  capture complete; RAM holds DEPTH valid samples.

Behaviour:
- **Reset:** state = IDLE. wr_en, busy, triggered and done = 0. wr_addr and trig_addr = 0. rst overrides everything, including a capture in progress; no partial done.
- **Trigger combine (combinational, zero latency):**
  - AND mode: hit = &(trig_in | ~trig_en).
  - OR mode: hit = |(trig_in & trig_en).
  - If trig_en == 0, hit = 1 in both modes (free-run capture).
- **Arm latching:** pre_eff = min(pre_depth, DEPTH-1). post_len = DEPTH-1-pre_eff. Both are latched when arm is accepted.
- **Write behaviour:** wr_en = 1 in exactly the PRE, WAIT and POST states. Every write advances wr_addr by 1, wrapping modulo DEPTH.
- **States:**
  - IDLE: wr_en = 0. On arm: wr_addr <= 0, counter <= pre_eff, triggered <= 0, done <= 0. Next state is PRE if pre_eff > 0, else WAIT.
  - PRE: one write per cycle; the trigger is ignored. After pre_eff writes, go to WAIT.
  - WAIT: one write per cycle. If hit is sampled high in a cycle, that cycle's write is the trigger sample: trig_addr <= wr_addr, triggered <= 1. Next state is POST (counter <= post_len), or DONE if post_len == 0.
  - POST: one write per cycle. After post_len writes, go to DONE.
  - DONE: wr_en = 0, busy = 0, done = 1. done holds until the next accepted arm.
- **Capture size:** total writes before DONE is at least DEPTH. The ring buffer then holds exactly pre_eff samples before trig_addr and post_len samples after it. The readout start address is (trig_addr - pre_eff) mod DEPTH.
- **arm handling:** arm is accepted only in IDLE or DONE. It is ignored while busy.
- **abort:** valid in any busy state. Next cycle state = IDLE, with wr_en, busy, triggered and done = 0. abort takes priority over a simultaneous hit or arm.
- **hit on the last PRE cycle:** ignored; the trigger is evaluated only in WAIT.
- **Input timing:** pre_depth, trig_mode and trig_en may change while busy. pre_depth is latched at arm. trig_mode and trig_en are used live.

Decomposition:
- **Shared package `analyzer_pkg`:**
  - State encoding: IDLE, PRE, WAIT, POST, DONE.
  - TRIG_MODE_AND = 0 and TRIG_MODE_OR = 1.
  - Reuse the operator/value codes from the trigger stage here as well.
- **Sub-module `trigger_combine`:** the purely combinational enable/mode reduction, kept separate so it can be reused for a multi-stage trigger.
- **Top-level FSM:** holds the FSM, counters and address logic.

Test Plan:
1. ADDR_WIDTH=4, pre_depth=4, OR mode, trig_en=0x01; arm at cycle 0; trig_in[0] high at cycle 8 → PRE writes addr 0-3 (cycles 1-4); WAIT writes addr 4-7 (cycles 5-8); trig_addr=7; POST writes addr 8-15 then 0-2 (cycles 9-19); done=1 from cycle 20; wr_en=0 from cycle 20.
2. AND mode, trig_en=0x03: trig_in=0x01 for 5 cycles, then 0x03 → triggered only on the 0x03 cycle. Repeat with trig_en=0x00 → trigger on the first WAIT cycle.
3. pre_depth=0 and pre_depth=DEPTH+… (i.e. ≥ DEPTH-1): pre_depth=0 → WAIT entered the cycle after arm. pre_depth ≥ DEPTH-1 → clamped to DEPTH-1, post_len=0, and done the cycle after the trigger write.
4. Hit held high during PRE → not accepted until the first WAIT cycle; trig_addr = pre_eff.
5. abort asserted mid-POST together with arm → IDLE next cycle, done=0, triggered=0, wr_en=0. A later arm restarts at wr_addr=0.
6. arm pulsed during WAIT is ignored (no restart). rst mid-POST → all outputs return to reset values the next cycle.
